ir_key_tx: RTL and testbench



---
 rtl/ir_key_tx_pkg.sv | 51 +++++
 rtl/ir_key_tx_carrier.sv | 34 +++
 rtl/ir_key_tx.sv | 159 +++++++++++++++
 tb/tb_ir_key_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_key_tx_pkg.sv
// Shared constants for the IR remote-control link: keypad codes, NEC-style
// frame timing in protocol units, and the transmitter state encoding.
// The receiver/decoder imports the same package so both ends agree on
// the frame shape.
package ir_key_tx_pkg;

  // Keypad codes produced by the keypad scanner.
  localparam logic [3:0] KEY_NONE    = 4'h0;
  localparam logic [3:0] KEY_SPEED_1 = 4'h1;
  localparam logic [3:0] KEY_SPEED_2 = 4'h2;
  localparam logic [3:0] KEY_SPEED_3 = 4'h3;
  localparam logic [3:0] KEY_OFF     = 4'h4;
  localparam logic [3:0] KEY_TIMER   = 4'h5;
  localparam logic [3:0] KEY_OSC     = 4'h6;
  localparam logic [3:0] KEY_MODE    = 4'h7;

  // Frame element durations, in protocol units.
  localparam int IR_LEAD_MARK_U  = 16;
  localparam int IR_LEAD_SPACE_U = 8;
  localparam int IR_BIT_MARK_U   = 1;
  localparam int IR_ONE_SPACE_U  = 3;
  localparam int IR_ZERO_SPACE_U = 1;
  localparam int IR_STOP_MARK_U  = 1;
  localparam int IR_FRAME_BITS   = 32;

  // Default device address carried in every frame.
  localparam logic [7:0] IR_ADDR_DEFAULT = 8'h00;

  // Transmitter states; the three *_MARK states are the only ones with the
  // envelope high.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LEAD_MARK  = 3'd1,
    ST_LEAD_SPACE = 3'd2,
    ST_BIT_MARK   = 3'd3,
    ST_BIT_SPACE  = 3'd4,
    ST_STOP_MARK  = 3'd5,
    ST_GAP        = 3'd6
  } ir_tx_state_e;

  // 32-bit payload, sent LSB first: addr, ~addr, data, ~data.
  // The complement bytes guarantee exactly 16 one-bits per frame, which
  // fixes the frame length regardless of key.
  function automatic logic [31:0] ir_frame_word(input logic [7:0] addr,
                                                input logic [3:0] key);
    logic [7:0] data;
    data = {4'h0, key};
    return {~data, data, ~addr, addr};
  endfunction

endpackage

// File: rtl/ir_key_tx_carrier.sv
// Carrier generator for the IR LED. While disabled the output is parked
// high with the divider cleared, so every mark starts on a full high
// half-period.
module ir_carrier_gen #(
  parameter int CARRIER_HALF = 658
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic carrier
);

  localparam int HW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CARRIER_HALF - 1);

  logic [HW-1:0] half_cnt;

  // Divide clk down to the carrier: toggle every CARRIER_HALF cycles while enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt <= '0;
      carrier  <= 1'b1;
    end else if (!en) begin
      half_cnt <= '0;
      carrier  <= 1'b1;
    end else if (half_cnt == HALF_LAST) begin
      half_cnt <= '0;
      carrier  <= ~carrier;
    end else begin
      half_cnt <= half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ir_key_tx.sv
// IR key transmitter: accepts a 4-bit key from the keypad scanner and sends
// it as an NEC-style frame (leader, 32 pulse-distance bits, stop mark,
// then an idle gap), modulated onto the carrier for the IR LED.
//
// Handshake: a key is taken on the clk edge where key_valid && key_ready.
// key_ready is a registered copy of (state == IDLE); it drops on the accept
// edge and returns only once the post-frame gap has elapsed. key_valid
// held while busy is simply waited on; key is sampled only on the accept
// edge, nothing is queued.
module ir_key_tx
  import ir_key_tx_pkg::*;
#(
  parameter int         UNIT_CYC     = 28125,
  parameter int         CARRIER_HALF = 658,
  parameter logic [7:0] IR_ADDR      = IR_ADDR_DEFAULT,
  parameter int         GAP_UNITS    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       ir_out,
  output logic       ir_env,
  output logic       tx_done
);

  // Unit counter must hold the longest state in units (leader or gap).
  localparam int MAX_UNITS = (GAP_UNITS > IR_LEAD_MARK_U) ? GAP_UNITS : IR_LEAD_MARK_U;
  localparam int CW        = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
  localparam int UW        = $clog2(MAX_UNITS);

  localparam logic [CW-1:0] CYC_LAST     = CW'(UNIT_CYC - 1);
  localparam logic [CW-1:0] CYC_PRE_LAST = CW'(UNIT_CYC - 2);
  localparam logic [UW-1:0] GAP_LAST     = UW'(GAP_UNITS - 1);
  localparam logic [4:0]    BIT_LAST     = 5'(IR_FRAME_BITS - 1);

  ir_tx_state_e   state;
  logic [CW-1:0]  cyc_cnt;
  logic [UW-1:0]  unit_cnt;
  logic [4:0]     bit_idx;
  logic [31:0]    shift_reg;
  logic [UW-1:0]  dur_last;
  logic           state_done;
  logic           carrier;

  // Last unit index of the current state; a bit space depends on the bit being sent.
  always_comb begin
    dur_last = '0;
    case (state)
      ST_LEAD_MARK:  dur_last = UW'(IR_LEAD_MARK_U - 1);
      ST_LEAD_SPACE: dur_last = UW'(IR_LEAD_SPACE_U - 1);
      ST_BIT_MARK:   dur_last = UW'(IR_BIT_MARK_U - 1);
      ST_BIT_SPACE:  dur_last = shift_reg[0] ? UW'(IR_ONE_SPACE_U - 1)
                                             : UW'(IR_ZERO_SPACE_U - 1);
      ST_STOP_MARK:  dur_last = UW'(IR_STOP_MARK_U - 1);
      ST_GAP:        dur_last = GAP_LAST;
      default:       dur_last = '0;
    endcase
  end

  // The current state has run its full units*UNIT_CYC cycles this cycle.
  assign state_done = (cyc_cnt == CYC_LAST) && (unit_cnt == dur_last);

  // Frame sequencer: state, timing counters, payload shifter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      key_ready <= 1'b1;
      ir_env    <= 1'b0;
      tx_done   <= 1'b0;
      cyc_cnt   <= '0;
      unit_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      tx_done <= 1'b0;
      if (state == ST_IDLE) begin
        if (key_valid && key_ready) begin
          state     <= ST_LEAD_MARK;
          ir_env    <= 1'b1;
          key_ready <= 1'b0;
          shift_reg <= ir_frame_word(IR_ADDR, key);
          cyc_cnt   <= '0;
          unit_cnt  <= '0;
          bit_idx   <= '0;
        end
      end else if (state_done) begin
        // Every state entry starts timing from zero.
        cyc_cnt  <= '0;
        unit_cnt <= '0;
        case (state)
          ST_LEAD_MARK: begin
            state  <= ST_LEAD_SPACE;
            ir_env <= 1'b0;
          end
          ST_LEAD_SPACE: begin
            state  <= ST_BIT_MARK;
            ir_env <= 1'b1;
          end
          ST_BIT_MARK: begin
            state  <= ST_BIT_SPACE;
            ir_env <= 1'b0;
          end
          ST_BIT_SPACE: begin
            shift_reg <= shift_reg >> 1;
            ir_env    <= 1'b1;
            if (bit_idx == BIT_LAST) begin
              state   <= ST_STOP_MARK;
              bit_idx <= '0;
            end else begin
              state   <= ST_BIT_MARK;
              bit_idx <= bit_idx + 1'b1;
            end
          end
          ST_STOP_MARK: begin
            state  <= ST_GAP;
            ir_env <= 1'b0;
          end
          ST_GAP: begin
            state     <= ST_IDLE;
            key_ready <= 1'b1;
          end
          default: begin
            state     <= ST_IDLE;
            ir_env    <= 1'b0;
            key_ready <= 1'b1;
          end
        endcase
      end else begin
        if (cyc_cnt == CYC_LAST) begin
          cyc_cnt  <= '0;
          unit_cnt <= unit_cnt + 1'b1;
        end else begin
          cyc_cnt <= cyc_cnt + 1'b1;
        end
        // Registered so tx_done is high during the final gap cycle, the one
        // in which the return to IDLE is taken (key_ready still low).
        if (state == ST_GAP && cyc_cnt == CYC_PRE_LAST && unit_cnt == GAP_LAST) begin
          tx_done <= 1'b1;
        end
      end
    end
  end

  // Carrier runs only during marks; parking it between marks restarts it high.
  ir_carrier_gen #(
    .CARRIER_HALF (CARRIER_HALF)
  ) u_carrier (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (ir_env),
    .carrier (carrier)
  );

  // Gate the carrier with the envelope so the LED is dark in every space.
  assign ir_out = ir_env & carrier;

endmodule

// File: tb/tb_ir_key_tx.sv
// Bench for ir_key_tx: a frame-level reference model expands each accepted
// key into its per-cycle envelope/carrier/tx_done sequence, and a pulse-width
// decoder turns the observed envelope back into bytes.
module tb_ir_key_tx;

  localparam int         UNIT_CYC     = 4;
  localparam int         CARRIER_HALF = 1;
  localparam int         GAP_UNITS    = 4;
  localparam logic [7:0] IR_ADDR      = 8'hA5;
  localparam int         U            = UNIT_CYC;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] key = 4'h0;
  logic       key_valid = 1'b0;
  logic       key_ready;
  logic       ir_out;
  logic       ir_env;
  logic       tx_done;

  ir_key_tx #(
    .UNIT_CYC     (UNIT_CYC),
    .CARRIER_HALF (CARRIER_HALF),
    .IR_ADDR      (IR_ADDR),
    .GAP_UNITS    (GAP_UNITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key       (key),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .ir_out    (ir_out),
    .ir_env    (ir_env),
    .tx_done   (tx_done)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  // scoreboard state
  int         checks = 0;
  int         errors = 0;
  logic [2:0] exp_q[$];          // per-cycle {env, out, done} of the frame in flight
  logic       prev_ready = 1'b1; // expected key_ready of the previous cycle
  int         accepts = 0;
  int         done_seen = 0;
  int         done_exp = 0;
  logic [3:0] last_key = 4'h0;
  int         runs[$];
  logic       run_lvl = 1'b0;
  int         run_len = 0;
  bit         collecting = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: a mark of n cycles with carrier starting high
  task automatic push_mark(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b1, ((i / CARRIER_HALF) % 2) == 0, 1'b0});
    end
  endtask

  task automatic push_space(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(3'b000);
  endtask

  task automatic build_frame(input logic [3:0] k);
    logic [7:0] b[4];
    b[0] = IR_ADDR;
    b[1] = ~IR_ADDR;
    b[2] = {4'h0, k};
    b[3] = ~b[2];
    push_mark(16 * U);
    push_space(8 * U);
    for (int i = 0; i < 32; i++) begin
      push_mark(U);
      push_space(b[i / 8][i % 8] ? 3 * U : U);
    end
    push_mark(U);
    push_space(GAP_UNITS * U);
    exp_q[exp_q.size() - 1] = 3'b001;
  endtask

  // decode observed envelope run lengths back into the four frame bytes
  task automatic decode_frame();
    logic [7:0] got_b[4];
    logic [7:0] exp_b[4];
    int         bad_marks;
    bad_marks = 0;
    exp_b[0] = IR_ADDR;
    exp_b[1] = ~IR_ADDR;
    exp_b[2] = {4'h0, last_key};
    exp_b[3] = ~exp_b[2];
    check_eq("run_count", runs.size(), 68);
    if (runs.size() == 68) begin
      check_eq("lead_mark", runs[0], 16 * U);
      check_eq("lead_space", runs[1], 8 * U);
      for (int i = 0; i < 32; i++) begin
        if (runs[2 + 2 * i] != U) bad_marks++;
        got_b[i / 8][i % 8] = (runs[3 + 2 * i] > 2 * U);
      end
      check_eq("bit_marks", bad_marks, 0);
      for (int j = 0; j < 4; j++) check_eq($sformatf("byte%0d", j), got_b[j], exp_b[j]);
      check_eq("stop_mark", runs[66], U);
      check_eq("gap", runs[67], GAP_UNITS * U);
    end
  endtask

  // one clock: model reacts at the edge, outputs compared on the falling edge
  task automatic tick();
    logic [3:0] e;
    @(posedge clk);
    if (prev_ready && key_valid) begin
      build_frame(key);
      last_key   = key;
      accepts++;
      collecting = 1'b1;
      runs.delete();
      run_lvl    = 1'b1;
      run_len    = 0;
    end
    if (exp_q.size() > 0) e = {1'b0, exp_q.pop_front()};
    else e = 4'b1000;
    prev_ready = e[3];
    if (e[0]) done_exp++;
    @(negedge clk);
    check_eq("outs", {28'h0, key_ready, ir_env, ir_out, tx_done}, {28'h0, e});
    if (tx_done === 1'b1) done_seen++;
    if (collecting) begin
      if (ir_env === run_lvl) run_len++;
      else begin
        runs.push_back(run_len);
        run_lvl = ir_env;
        run_len = 1;
      end
      if (e[0]) begin
        runs.push_back(run_len);
        collecting = 1'b0;
        decode_frame();
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 700 && exp_q.size() > 0; i++) tick();
    repeat (2) tick();
  endtask

  task automatic send_pulse(input logic [3:0] k);
    key = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  // asynchronous reset, checked immediately, held two cycles
  task automatic do_reset();
    rst_n = 1'b0;
    key_valid = 1'b0;
    #1;
    check_eq("rst_ready", key_ready, 1);
    check_eq("rst_env", ir_env, 0);
    check_eq("rst_out", ir_out, 0);
    check_eq("rst_done", tx_done, 0);
    exp_q.delete();
    prev_ready = 1'b1;
    collecting = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int a0;
    #2;
    do_reset();
    repeat (3) tick();

    // single frame, key 3
    send_pulse(4'h3);
    drain();

    // back-to-back: valid held, key changes after the first accept
    a0 = accepts;
    key = 4'h1;
    key_valid = 1'b1;
    tick();
    key = 4'h2;
    for (int i = 0; i < 600 && accepts < a0 + 2; i++) tick();
    key_valid = 1'b0;
    drain();

    // ignore while busy
    send_pulse(4'h5);
    repeat (50) tick();
    send_pulse(4'h9);
    drain();

    // reset during the first bit space, then a fresh frame with key 0
    send_pulse(4'h6);
    repeat (104) tick();
    do_reset();
    repeat (2) tick();
    send_pulse(4'h0);
    drain();

    // randomized frames with stray requests and occasional resets
    for (int f = 0; f < 6; f++) begin
      repeat ($urandom_range(0, 4)) tick();
      send_pulse(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 480)) tick();
        do_reset();
      end else begin
        for (int i = 0; i < 520; i++) begin
          key_valid = ($urandom_range(0, 15) == 0);
          key = 4'($urandom_range(0, 15));
          tick();
        end
      end
      key_valid = 1'b0;
      drain();
    end

    check_eq("tx_done_cnt", done_seen, done_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
